// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter with 1-4 beat bursts
// sharing one single-port unified memory; read data one cycle later.
module mem_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [1:0]    m0_len,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_beat,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [1:0]    m1_len,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_beat,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t state;
  state_t nstate;

  logic          owner;
  logic          last;
  logic          cur_we;
  logic [1:0]    cnt;
  logic [AW-1:0] cur_addr;
  logic          rd_pend;
  logic          rd_id;

  logic          any;
  logic          win;
  logic          acc;
  logic          sel;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [1:0]    w_len;
  logic [DW-1:0] w_wdata;

  // Round-robin pick: on a tie the master that did not win last goes
  always_comb begin
    any = m0_req | m1_req;
    win = m1_req & (~m0_req | ~last);
    acc = (state == IDLE) & any;
  end

  // Route the winning master's request fields
  always_comb begin
    w_we    = win ? m1_we    : m0_we;
    w_addr  = win ? m1_addr  : m0_addr;
    w_len   = win ? m1_len   : m0_len;
    w_wdata = win ? m1_wdata : m0_wdata;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  // Next state: multi-beat grants enter BURST, leave after last beat
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (acc && (w_len != 2'd0)) begin
          nstate = BURST;
        end
      end
      BURST: begin
        if (cnt == 2'd1) begin
          nstate = IDLE;
        end
      end
    endcase
  end

  // Burst bookkeeping and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner    <= 1'b0;
      last     <= 1'b1;
      cur_we   <= 1'b0;
      cnt      <= 2'd0;
      cur_addr <= '0;
    end else if (acc) begin
      last <= win;
      if (w_len != 2'd0) begin
        owner    <= win;
        cnt      <= w_len;
        cur_addr <= w_addr + 1'b1;
        cur_we   <= w_we;
      end
    end else if (state == BURST) begin
      cur_addr <= cur_addr + 1'b1;
      cnt      <= cnt - 1'b1;
    end
  end

  // Remember which master the read beat of this cycle belongs to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_id   <= 1'b0;
    end else begin
      rd_pend <= mem_en & ~mem_we;
      rd_id   <= sel;
    end
  end

  // Memory strobes, grants and beats; everything held low in reset
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_beat   = 1'b0;
    m1_beat   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    sel       = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (any) begin
            sel       = win;
            m0_gnt    = ~win;
            m1_gnt    = win;
            m0_beat   = ~win;
            m1_beat   = win;
            mem_en    = 1'b1;
            mem_we    = w_we;
            mem_addr  = w_addr;
            mem_wdata = w_wdata;
          end
        end
        BURST: begin
          sel       = owner;
          busy      = 1'b1;
          m0_beat   = ~owner;
          m1_beat   = owner;
          mem_en    = 1'b1;
          mem_we    = cur_we;
          mem_addr  = cur_addr;
          mem_wdata = owner ? m1_wdata : m0_wdata;
        end
      endcase
    end
  end

  // Read return goes only to the master that issued the beat
  always_comb begin
    m0_rvalid = rd_pend & ~rd_id & ~rst;
    m1_rvalid = rd_pend & rd_id & ~rst;
    m0_rdata  = m0_rvalid ? mem_rdata : '0;
    m1_rdata  = m1_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic
// checked against a beat-schedule model of the arbiter.
module tb_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  typedef struct packed {
    logic        m;
    logic        we;
    logic [9:0]  a;
    logic [21:0] s;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m0_gnt, m0_beat, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [1:0]    m0_len;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_gnt, m1_beat, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [1:0]    m1_len;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic          clr, pl_en;
  logic [AW-1:0] pl_a;
  logic [DW-1:0] pl_d;
  logic [DW-1:0] mem [1024];

  int pass_n = 0;
  int tot_n  = 0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_len(m0_len), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
    .m0_beat(m0_beat), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_len(m1_len), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
    .m1_beat(m1_beat), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory with bench-side fill/preload
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hC000_0000 | 32'(i * 5);
    end else if (pl_en) begin
      mem[pl_a] <= pl_d;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_in();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_len = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_len = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_in();
    nxt();
    nxt();
    rst = 0;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pl_en = 1; pl_a = a; pl_d = d;
    nxt();
    pl_en = 0;
  endtask

  function automatic logic [9:0] rnd_addr();
    if ($urandom % 4 == 0) return 10'(1020 + $urandom % 4);
    return 10'($urandom);
  endfunction

  task automatic test_reset();
    logic [8:0] o;
    rst = 1;
    m0_req = 1; m0_we = 1; m0_addr = 10'd33; m0_wdata = 32'h1234;
    m1_req = 1; m1_we = 0; m1_addr = 10'd44; m1_len = 2'd3;
    smp();
    o = {m0_gnt, m1_gnt, m0_beat, m1_beat, m0_rvalid,
         m1_rvalid, mem_en, mem_we, busy};
    tot_n++;
    if (o !== 9'd0) $display("FAIL reset_ctrl: got %b want 0", o);
    else pass_n++;
    tot_n++;
    if ({mem_addr, mem_wdata} !== '0)
      $display("FAIL reset_bus: got %h %h want 0", mem_addr, mem_wdata);
    else pass_n++;
    tot_n++;
    if ((m0_rdata | m1_rdata) !== '0)
      $display("FAIL reset_rdata: got %h %h want 0", m0_rdata, m1_rdata);
    else pass_n++;
    nxt();
    idle_in();
  endtask

  task automatic test_single_read();
    do_reset();
    preload(10'd100, 32'd65);
    m0_req = 1; m0_we = 0; m0_addr = 10'd100; m0_len = 0;
    smp();
    tot_n++;
    if ({m0_gnt, m0_beat, mem_en, mem_we, m1_gnt, m1_beat} !== 6'b111000)
      $display("FAIL sr_gnt: got %b%b%b%b%b%b want 111000", m0_gnt,
               m0_beat, mem_en, mem_we, m1_gnt, m1_beat);
    else pass_n++;
    tot_n++;
    if (mem_addr !== 10'd100)
      $display("FAIL sr_addr: got %0d want 100", mem_addr);
    else pass_n++;
    nxt();
    idle_in();
    smp();
    tot_n++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, 32'd65})
      $display("FAIL sr_rdata: got %b %0d want 1 65", m0_rvalid, m0_rdata);
    else pass_n++;
    tot_n++;
    if ({m1_rvalid, m1_rdata, m1_gnt, mem_en} !== '0)
      $display("FAIL sr_m1: got %b %h %b %b want 0", m1_rvalid, m1_rdata,
               m1_gnt, mem_en);
    else pass_n++;
    nxt();
  endtask

  task automatic test_alternate();
    logic [1:0] eg;
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 10'd10; m0_len = 0;
    m1_req = 1; m1_we = 0; m1_addr = 10'd20; m1_len = 0;
    for (int i = 0; i < 8; i++) begin
      smp();
      eg = (i % 2 == 1) ? 2'b10 : 2'b01;
      tot_n++;
      if ({m1_gnt, m0_gnt} !== eg)
        $display("FAIL alt_gnt%0d: got %b want %b", i, {m1_gnt, m0_gnt}, eg);
      else pass_n++;
      nxt();
    end
    idle_in();
    nxt();
  endtask

  task automatic test_wrap_burst();
    logic [8:0] eo, ao;
    logic [9:0] ea;
    logic [31:0] ed;
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 10'd1022; m1_len = 2'd3;
    m1_wdata = 32'd68;
    for (int k = 0; k < 4; k++) begin
      smp();
      ea = 10'(1022 + k);
      eo = {k == 0, 1'b1, 1'b1, 1'b1, k != 0, 4'b0000};
      ao = {m1_gnt, m1_beat, mem_en, mem_we, busy,
            m0_rvalid, m1_rvalid, m0_gnt, m0_beat};
      tot_n++;
      if (ao !== eo) $display("FAIL wb_ctrl%0d: got %b want %b", k, ao, eo);
      else pass_n++;
      tot_n++;
      if ({mem_addr, mem_wdata} !== {ea, 32'(68 + k)})
        $display("FAIL wb_bus%0d: got %0d/%0d want %0d/%0d", k, mem_addr,
                 mem_wdata, ea, 68 + k);
      else pass_n++;
      nxt();
      m1_req = 0; m1_addr = 10'd5; m1_len = 0;
      m1_wdata = 32'(69 + k);
    end
    smp();
    tot_n++;
    if ({busy, mem_en, m0_rvalid, m1_rvalid} !== 4'b0)
      $display("FAIL wb_end: got %b%b%b%b want 0000", busy, mem_en,
               m0_rvalid, m1_rvalid);
    else pass_n++;
    for (int k = 0; k < 4; k++) begin
      ea = 10'(1022 + k);
      ed = mem[ea];
      tot_n++;
      if (ed !== 32'(68 + k))
        $display("FAIL wb_mem%0d: got %0d want %0d", ea, ed, 68 + k);
      else pass_n++;
    end
    nxt();
  endtask

  task automatic test_burst_wait();
    logic [1:0] eg [5];
    logic [1:0] ev [5];
    logic [9:0] ea [5];
    logic [31:0] ed [5];
    eg = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00};
    ev = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10};
    ea = '{10'd100, 10'd101, 10'd102, 10'd400, 10'd0};
    ed = '{32'h0, 32'h111, 32'h222, 32'h333, 32'h444};
    do_reset();
    preload(10'd100, 32'h111);
    preload(10'd101, 32'h222);
    preload(10'd102, 32'h333);
    preload(10'd400, 32'h444);
    m0_req = 1; m0_we = 0; m0_addr = 10'd100; m0_len = 2'd2;
    for (int c = 0; c < 5; c++) begin
      smp();
      tot_n++;
      if ({m1_gnt, m0_gnt} !== eg[c])
        $display("FAIL bw_gnt%0d: got %b want %b", c, {m1_gnt, m0_gnt}, eg[c]);
      else pass_n++;
      tot_n++;
      if ({m1_rvalid, m0_rvalid} !== ev[c])
        $display("FAIL bw_rv%0d: got %b want %b", c,
                 {m1_rvalid, m0_rvalid}, ev[c]);
      else pass_n++;
      if (c < 4) begin
        tot_n++;
        if ({mem_en, mem_addr} !== {1'b1, ea[c]})
          $display("FAIL bw_addr%0d: got %b %0d want 1 %0d", c, mem_en,
                   mem_addr, ea[c]);
        else pass_n++;
      end
      if (c > 0) begin
        tot_n++;
        if ((m0_rdata | m1_rdata) !== ed[c])
          $display("FAIL bw_data%0d: got %h want %h", c,
                   m0_rdata | m1_rdata, ed[c]);
        else pass_n++;
      end
      nxt();
      if (c == 0) begin
        m0_req = 0;
        m1_req = 1; m1_we = 0; m1_addr = 10'd400; m1_len = 0;
      end
      if (c == 3) m1_req = 0;
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] o;
    do_reset();
    preload(10'd200, 32'hABC);
    m0_req = 1; m0_we = 0; m0_addr = 10'd200; m0_len = 2'd3;
    smp();
    tot_n++;
    if (m0_gnt !== 1'b1) $display("FAIL rm_gnt: got %b want 1", m0_gnt);
    else pass_n++;
    nxt();
    m0_req = 0;
    #2;
    rst = 1;
    smp();
    o = {m0_gnt, m1_gnt, m0_beat, m1_beat, m0_rvalid,
         m1_rvalid, mem_en, mem_we, busy};
    tot_n++;
    if ({o, mem_addr} !== '0)
      $display("FAIL rm_in_rst: got %b %0d want 0", o, mem_addr);
    else pass_n++;
    #1;
    rst = 0;
    for (int c = 0; c < 2; c++) begin
      nxt();
      smp();
      tot_n++;
      if ({m0_beat, m0_rvalid, mem_en, busy} !== 4'b0)
        $display("FAIL rm_after%0d: got %b%b%b%b want 0000", c, m0_beat,
                 m0_rvalid, mem_en, busy);
      else pass_n++;
    end
    nxt();
    m0_req = 1; m0_we = 0; m0_addr = 10'd200; m0_len = 0;
    smp();
    tot_n++;
    if ({m0_gnt, mem_addr} !== {1'b1, 10'd200})
      $display("FAIL rm_regnt: got %b %0d want 1 200", m0_gnt, mem_addr);
    else pass_n++;
    nxt();
    m0_req = 0;
    smp();
    tot_n++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, 32'hABC})
      $display("FAIL rm_rdata: got %b %h want 1 abc", m0_rvalid, m0_rdata);
    else pass_n++;
    nxt();
  endtask

  task automatic test_back_to_back();
    do_reset();
    preload(10'd300, 32'hA1);
    preload(10'd301, 32'hA2);
    m0_req = 1; m0_we = 0; m0_addr = 10'd300; m0_len = 2'd1;
    smp();
    tot_n++;
    if (m0_gnt !== 1'b1) $display("FAIL bb_gnt0: got %b want 1", m0_gnt);
    else pass_n++;
    nxt();
    m0_req = 0;
    smp();
    tot_n++;
    if ({m0_rvalid, m0_rdata, mem_addr, busy} !== {1'b1, 32'hA1, 10'd301, 1'b1})
      $display("FAIL bb_beat1: got %b %h %0d %b want 1 a1 301 1",
               m0_rvalid, m0_rdata, mem_addr, busy);
    else pass_n++;
    nxt();
    m1_req = 1; m1_we = 1; m1_addr = 10'd302; m1_len = 0;
    m1_wdata = 32'hBEEF;
    smp();
    tot_n++;
    if ({m1_gnt, m0_rvalid, m1_rvalid, m0_rdata} !== {3'b110, 32'hA2})
      $display("FAIL bb_coinc: got %b%b%b %h want 110 a2", m1_gnt,
               m0_rvalid, m1_rvalid, m0_rdata);
    else pass_n++;
    tot_n++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 10'd302, 32'hBEEF})
      $display("FAIL bb_wr: got %b %0d %h want 1 302 beef", mem_we,
               mem_addr, mem_wdata);
    else pass_n++;
    nxt();
    m1_req = 0;
    smp();
    tot_n++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00)
      $display("FAIL bb_norv: got %b%b want 00", m0_rvalid, m1_rvalid);
    else pass_n++;
    tot_n++;
    if ({mem[300], mem[301], mem[302]} !== {32'hA1, 32'hA2, 32'hBEEF})
      $display("FAIL bb_mem: got %h %h %h want a1 a2 beef", mem[300],
               mem[301], mem[302]);
    else pass_n++;
    nxt();
  endtask

  task automatic test_random();
    beat_t       q[$];
    beat_t       e;
    logic [31:0] sh [1024];
    bit          pr [2];
    bit          pw [2];
    logic [9:0]  pa [2];
    logic [1:0]  pl [2];
    logic [21:0] ps [2];
    bit          ba [2];
    logic [9:0]  bad [2];
    int          bl [2];
    int          bk [2];
    logic [21:0] bs [2];
    bit          last_m, rv_v, rv_m, w, een, ewe, ebusy;
    logic [31:0] rv_d, ewd;
    logic [9:0]  eadr;
    logic [1:0]  eg, eb;
    logic [7:0]  eo, ao;
    do_reset();
    foreach (sh[i]) sh[i] = mem[i];
    last_m = 1; rv_v = 0; rv_m = 0; rv_d = '0;
    for (int m = 0; m < 2; m++) begin
      pr[m] = 0; ba[m] = 0; bk[m] = 0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pr[m] && ($urandom % 3 == 0)) begin
          pr[m] = 1; pw[m] = 1'($urandom); pa[m] = rnd_addr();
          pl[m] = 2'($urandom); ps[m] = 22'($urandom);
        end
      end
      m0_req = pr[0]; m0_we = pw[0]; m0_addr = pa[0]; m0_len = pl[0];
      m1_req = pr[1]; m1_we = pw[1]; m1_addr = pa[1]; m1_len = pl[1];
      m0_wdata = ba[0] ? {bs[0], bad[0] + 10'(bk[0])} : {ps[0], pa[0]};
      m1_wdata = ba[1] ? {bs[1], bad[1] + 10'(bk[1])} : {ps[1], pa[1]};
      smp();
      eg = 0; eb = 0; een = 0; ewe = 0; eadr = 0; ewd = 0;
      ebusy = q.size() != 0;
      if (q.size() != 0) begin
        e = q.pop_front();
        eb[e.m] = 1; een = 1; ewe = e.we; eadr = e.a; ewd = {e.s, e.a};
      end else if (pr[0] || pr[1]) begin
        w = (pr[0] && pr[1]) ? !last_m : pr[1];
        eg[w] = 1; eb[w] = 1; een = 1; ewe = pw[w];
        eadr = pa[w]; ewd = {ps[w], pa[w]}; last_m = w;
        for (int k = 1; k <= int'(pl[w]); k++) begin
          e.m = w; e.we = pw[w]; e.a = pa[w] + 10'(k); e.s = ps[w];
          q.push_back(e);
        end
      end
      eo = {eg, eb, een, ebusy, rv_v & rv_m, rv_v & !rv_m};
      ao = {m1_gnt, m0_gnt, m1_beat, m0_beat, mem_en, busy,
            m1_rvalid, m0_rvalid};
      tot_n++;
      if (ao !== eo) $display("FAIL rnd_ctrl@%0d: got %b want %b", cyc, ao, eo);
      else pass_n++;
      if (een) begin
        tot_n++;
        if ({mem_we, mem_addr} !== {ewe, eadr})
          $display("FAIL rnd_addr@%0d: got %b %0d want %b %0d", cyc,
                   mem_we, mem_addr, ewe, eadr);
        else pass_n++;
      end
      if (een && ewe) begin
        tot_n++;
        if (mem_wdata !== ewd)
          $display("FAIL rnd_wdata@%0d: got %h want %h", cyc, mem_wdata, ewd);
        else pass_n++;
      end
      if (rv_v) begin
        tot_n++;
        if ((rv_m ? m1_rdata : m0_rdata) !== rv_d)
          $display("FAIL rnd_rdata@%0d: got %h want %h", cyc,
                   rv_m ? m1_rdata : m0_rdata, rv_d);
        else pass_n++;
      end
      rv_v = een && !ewe;
      rv_m = eb[1];
      rv_d = sh[eadr];
      if (een && ewe) sh[eadr] = ewd;
      for (int m = 0; m < 2; m++) begin
        if (eb[m]) begin
          if (eg[m]) begin
            ba[m] = 1; bad[m] = pa[m]; bl[m] = int'(pl[m]);
            bs[m] = ps[m]; bk[m] = 1; pr[m] = 0;
          end else begin
            bk[m]++;
          end
          if (ba[m] && bk[m] > bl[m]) ba[m] = 0;
        end
      end
      nxt();
    end
    idle_in();
    nxt();
  endtask

  initial begin
    rst = 1; clr = 1; pl_en = 0; pl_a = '0; pl_d = '0;
    idle_in();
    nxt();
    clr = 0;
    test_reset();
    test_single_read();
    test_alternate();
    test_wrap_burst();
    test_burst_wait();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter with burst sequencing that shares the processor's single-port unified instruction/data memory between two requesters. Typical hookup: requester 0 is the mips32 data port, requester 1 is a host loader/DMA that preloads programs and input buffers such as cipher text. Each accepted request runs 1–4 consecutive word beats at incrementing addresses. Read data returns one cycle after each beat.

## Interface
- AW, 10, memory word-address width
- DW, 32, data width

Ports:
- clk  in  1  single system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- mN_req  in  1  request, N = 0,1; held high until mN_gnt
- mN_we  in  1  1 = write burst, 0 = read burst; valid with req
- mN_addr  in  AW  start word address; valid with req
- mN_len  in  2  beats minus one (0..3); valid with req
- mN_wdata  in  DW  write data for the current beat
- mN_gnt  out  1  one-cycle pulse: request accepted, beat 0 issued this cycle
- mN_beat  out  1  high in every cycle a beat of N's burst is issued to memory
- mN_rvalid  out  1  read data valid, one cycle after a read beat
- mN_rdata  out  DW  read data; valid only while mN_rvalid is high
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory word address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after mem_en with mem_we = 0
- busy  out  1  high while a multi-beat burst is in progress (BURST state)

## Operation
- State machine states:
  - IDLE: accepts one request per cycle.
  - BURST: finishes the beats that remain after beat 0.
- Registers:
  - owner: 1 bit, the master that owns the current burst.
  - cnt: 2 bits, beats remaining.
  - cur_addr: AW bits.
  - cur_we: 1 bit.
  - last: 1 bit, round-robin pointer.
  - rd_pend, rd_id: the in-flight read.
- IDLE, no requests: mem_en = 0.
- IDLE, one requester: that requester wins.
- IDLE, both requesting: the master not equal to `last` wins.
- Acceptance, same cycle and combinational from the winner's inputs:
  - mN_gnt = 1 and mN_beat = 1.
  - mem_en = 1.
  - mem_we = mN_we, mem_addr = mN_addr, mem_wdata = mN_wdata.
- Acceptance, registered at the clock edge:
  - last <= winner.
  - If len = 0: stay in IDLE.
  - If len > 0: owner <= winner, cnt <= len, cur_addr <= addr + 1, cur_we <= we, go to BURST.
- BURST, every cycle:
  - mem_en = 1, mem_we = cur_we, mem_addr = cur_addr, mem_wdata = owner's live mN_wdata.
  - owner's beat = 1.
  - cur_addr <= cur_addr + 1, cnt <= cnt − 1.
- BURST exits to IDLE after the beat issued with cnt = 1.
- BURST ignores all requests; the losing master's req stays high and waits.
- Address arithmetic is modulo 2^AW: 2^AW − 1 wraps to 0.
- Write data: the requester presents beat k+1's data the cycle after beat k. Beat 0 data is present with req.
- Read return: rvalid and rdata are routed to the master recorded for that beat, one cycle after the beat. mN_rdata = mem_rdata.
- The unselected master's rvalid = 0. Its rdata value is don't-care.
- A requester that keeps req high after gnt is making a new request; it is re-arbitrated in the next IDLE cycle.

## Timing
- Reset (asynchronous): while rst = 1, all outputs are 0 (gnt, beat, rvalid, mem_en, mem_we, busy, and all data/address outputs).
- Registers on reset:
  - state = IDLE, cnt = 0, rd_pend = 0.
  - last = 1, so m0 wins the first tie.
- Reset mid-burst: the remaining beats are abandoned. The rvalid of the in-flight read is suppressed, even if rst deasserts before the next edge.
- Latency:
  - gnt: same cycle as req (IDLE).
  - Read data: beat cycle + 1.
  - A len = L burst occupies memory for L+1 consecutive cycles.
- Throughput:
  - Single-beat requests can be accepted every cycle.
  - After a burst, the first IDLE cycle arbitrates immediately, with no dead cycle beyond the BURST→IDLE transition.
- busy goes high the cycle after gnt and falls after the final beat.
- Simultaneous events:
  - Both masters requesting in IDLE: exactly one gnt.
  - A read return for the previous burst can coincide with beat 0 of a new burst, including for the other master. Each master's rvalid follows its own recorded beat.
- rvalid never asserts for write beats.

## Test plan
- m0 single read of addr 100 with mem[100] = 65 -> m0_gnt and mem_en in the same cycle with mem_addr = 100; next cycle m0_rvalid = 1, m0_rdata = 65; m1 outputs stay 0.
- m0 and m1 both hold single-beat reads continuously after reset -> grants alternate m0, m1, m0, m1 with one gnt per cycle and no starvation.
- m1 write burst, len = 3, addr = 1022, AW = 10, data 68, 69, 70, 71 supplied per beat -> writes to 1022, 1023, 0, 1 with matching data; busy high for 3 cycles; no rvalid.
- m0 read burst, len = 2, from addr 100 while m1 requests one cycle later -> m1 waits; m1_gnt lands on the first IDLE cycle after m0's third beat; m0_rvalid pulses 3 times with consecutive addresses' data.
- rst asserted during the second beat of a len = 3 read -> all outputs 0 immediately; no further beats or rvalid; after release, a new m0 request is granted and completes normally.
- Back-to-back: m0 len = 1 read, then m1 single write in the same cycle as m0's last read return -> m0_rvalid and m1_gnt coincide; routing is correct; memory contents are as expected.
